snake_tile_renderer: RTL

- Pixel source for the VGA path. It answers the display controller's pixel address (ADDRH/ADDRV) with an 8-bit colour.
- Holds a 40x30 grid of 16x16-pixel tiles covering 640x480. Game logic writes the grid; the VGA side reads it.
- Performs a hardware clear sweep after reset and on request.
- Its COUT feeds the VGA wrapper's CIN.

---
 rtl/snake_pkg.sv | 40 ++++
 rtl/snake_tile_renderer_tile_ram.sv | 29 ++
 rtl/snake_tile_renderer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: tile types, grid geometry and colours.
// Used by the tile renderer and the game state machine.
package snake_pkg;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_BODY  = 2'd1,
        TILE_HEAD  = 2'd2,
        TILE_FOOD  = 2'd3
    } tile_t;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } sweep_state_t;

    localparam logic [5:0]  GRID_W     = 6'd40;
    localparam logic [4:0]  GRID_H     = 5'd30;
    localparam int          TILE_SHIFT = 4;
    localparam logic [9:0]  SCREEN_W   = 10'd640;
    localparam logic [8:0]  SCREEN_H   = 9'd480;
    localparam int          NUM_TILES  = 1200;
    localparam logic [10:0] LAST_IDX   = 11'd1199;

    localparam logic [7:0] DEF_COL_EMPTY = 8'h00;
    localparam logic [7:0] DEF_COL_BODY  = 8'h1C;
    localparam logic [7:0] DEF_COL_HEAD  = 8'h3F;
    localparam logic [7:0] DEF_COL_FOOD  = 8'hE0;

    // y*40 + x built from shifts so no multiplier is inferred
    function automatic logic [10:0] tile_index(
        input logic [5:0] x,
        input logic [4:0] y
    );
        logic [10:0] yw;
        yw = {6'd0, y};
        return (yw << 5) + (yw << 3) + {5'd0, x};
    endfunction

endpackage

// File: rtl/snake_tile_renderer_tile_ram.sv
// 1200x2 simple dual-port tile store, registered read-first read port.
// No reset on the array so it maps onto block RAM.
module tile_ram
    import snake_pkg::*;
#(
    parameter int DEPTH = NUM_TILES,
    parameter int AW    = 11
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [1:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [1:0]    rdata_o
);

    logic [1:0] mem_q [DEPTH];
    logic [1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/snake_tile_renderer.sv
// Tile-grid pixel source: 3-stage read pipeline for the VGA side,
// write port plus clear-sweep FSM for the game side.
module snake_tile_renderer
    import snake_pkg::*;
#(
    parameter logic [7:0] COL_EMPTY = DEF_COL_EMPTY,
    parameter logic [7:0] COL_BODY  = DEF_COL_BODY,
    parameter logic [7:0] COL_HEAD  = DEF_COL_HEAD,
    parameter logic [7:0] COL_FOOD  = DEF_COL_FOOD
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [9:0] ADDRH,
    input  logic [8:0] ADDRV,
    output logic [7:0] COUT,
    input  logic       WR_EN,
    input  logic [5:0] WR_X,
    input  logic [4:0] WR_Y,
    input  logic [1:0] WR_TYPE,
    input  logic       CLEAR,
    output logic       BUSY
);

    sweep_state_t state_q, state_d;
    logic [10:0]  cnt_q, cnt_d;

    logic         ram_we;
    logic [10:0]  ram_waddr;
    logic [1:0]   ram_wdata;
    logic [1:0]   ram_rdata;

    logic         rd_ok;
    logic [10:0]  rd_idx;
    logic [10:0]  s1_idx_q;
    logic         s1_ok_q;
    logic         s2_ok_q;
    logic [7:0]   cout_q, cout_d;

    // Stage 1: tile index and visible-area flag
    assign rd_ok  = (ADDRH < SCREEN_W) && (ADDRV < SCREEN_H);
    assign rd_idx = rd_ok ? tile_index(ADDRH[9:TILE_SHIFT],
                                       ADDRV[8:TILE_SHIFT])
                          : 11'd0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_idx_q <= 11'd0;
            s1_ok_q  <= 1'b0;
            s2_ok_q  <= 1'b0;
            cout_q   <= 8'h00;
        end else begin
            s1_idx_q <= rd_idx;
            s1_ok_q  <= rd_ok;
            s2_ok_q  <= s1_ok_q;
            cout_q   <= cout_d;
        end
    end

    // Stage 3: colour map, blanked outside the screen and during a sweep
    always_comb begin
        cout_d = COL_EMPTY;
        case (tile_t'(ram_rdata))
            TILE_EMPTY: cout_d = COL_EMPTY;
            TILE_BODY:  cout_d = COL_BODY;
            TILE_HEAD:  cout_d = COL_HEAD;
            TILE_FOOD:  cout_d = COL_FOOD;
            default:    cout_d = COL_EMPTY;
        endcase
        if (!s2_ok_q) begin
            cout_d = 8'h00;
        end else if (BUSY) begin
            cout_d = COL_EMPTY;
        end
    end

    assign COUT = cout_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_SWEEP;
            cnt_q   <= 11'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_waddr = tile_index(WR_X, WR_Y);
        ram_wdata = WR_TYPE;
        case (state_q)
            ST_IDLE: begin
                if (CLEAR) begin
                    state_d = ST_SWEEP;
                    cnt_d   = 11'd0;
                end else if (WR_EN && (WR_X < GRID_W) && (WR_Y < GRID_H)) begin
                    ram_we = 1'b1;
                end
            end
            ST_SWEEP: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = TILE_EMPTY;
                if (CLEAR) begin
                    cnt_d = 11'd0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = 11'd0;
            end
        endcase
    end

    assign BUSY = (state_q == ST_SWEEP);

    tile_ram #(
        .DEPTH (NUM_TILES),
        .AW    (11)
    ) u_tile_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (s1_idx_q),
        .rdata_o (ram_rdata)
    );

endmodule
